linescanner_capture_sequencer: RTL and testbench
================================================

Name: linescanner_capture_sequencer

Overview:
Parametrised next-generation line-scan sensor front end.
- Drives the exposure/readout control strobes (rst_cvc, rst_cds, sample) from run-time programmable phase lengths, with single-shot or free-running mode.
- Generates load_pulse after a programmable delay from the rising edge of end_adc.
- Frames the incoming pixel stream into indexed, line-delimited, registered output with overflow detection.
- Sits between the sensor pins and the downstream line buffer/DMA.

Parameters:
DATA_WIDTH, 8, pixel data width
CNT_WIDTH, 8, width of every phase/delay counter and timing input
LINE_PIXELS, 2048, maximum accepted pixels per line; derived localparam IDX_W = $clog2(LINE_PIXELS)
LINE_CNT_WIDTH, 16, width of the line counter

Ports:
pixel_clock  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  arm exposure sequence
single_shot  in  1  1: one sequence per enable assertion; 0: free-running
t_cvc  in  CNT_WIDTH  CVC phase length minus 1
t_cds  in  CNT_WIDTH  CDS phase length minus 1
t_sample  in  CNT_WIDTH  sample phase length minus 1
t_hold  in  CNT_WIDTH  hold phase length minus 1
load_delay  in  CNT_WIDTH  end_adc-rise-to-load_pulse delay minus 1
end_adc  in  1  sensor ADC-done flag
lval  in  1  sensor line-valid
data  in  DATA_WIDTH  sensor pixel data
rst_cvc  out  1  CVC reset strobe (active low)
rst_cds  out  1  CDS reset strobe (active low)
sample  out  1  sample strobe (active high)
load_pulse  out  1  one-cycle load strobe
busy  out  1  exposure FSM not in IDLE
pixel_data  out  DATA_WIDTH  registered pixel
pixel_valid  out  1  pixel_data valid
pixel_index  out  IDX_W  index of pixel_data within the line
line_start  out  1  high with the first valid pixel of a line
line_end  out  1  one-cycle pulse on the cycle after lval falls
line_count  out  LINE_CNT_WIDTH  completed lines, wraps
overflow  out  1  sticky: line exceeded LINE_PIXELS

Behaviour:
Reset values: rst_cvc=1, rst_cds=1, sample=0, load_pulse=0, busy=0, pixel_valid=0, line_start=0, line_end=0, pixel_index=0, line_count=0, overflow=0, pixel_data=0. Both FSMs go to IDLE; counters clear.

Exposure FSM: IDLE -> CVC -> CDS -> SAMPLE -> HOLD -> IDLE. All outputs are registered.
- IDLE: if enable and (armed or !single_shot), latch t_* into shadow registers, rst_cvc<=0, go to CVC. Timing-input changes mid-sequence are ignored.
- Each phase lasts exactly t_x+1 cycles. On leaving a phase:
  - CVC: rst_cds<=0
  - CDS: sample<=1
  - SAMPLE: sample<=0
  - HOLD: rst_cvc<=1, rst_cds<=1
- Resulting widths: rst_cvc low = sum of (t_x+1) over all four phases; sample high = t_sample+1.
- armed: set in IDLE when enable=0; cleared on sequence start while single_shot=1.
- Free-running: next sequence starts the cycle after return to IDLE when enable=1 (one IDLE cycle between sequences).
- enable falling mid-sequence does not abort; the sequence completes.
- busy=1 in all states except IDLE.

Load FSM: IDLE -> DELAY -> PULSE -> WAIT_LOW.
- end_adc is registered once for edge detection; a rising edge in IDLE enters DELAY.
- DELAY lasts load_delay+1 cycles; then load_pulse=1 for exactly 1 cycle.
- WAIT_LOW holds until end_adc=0, then returns to IDLE.
- end_adc falling during DELAY: the pulse is still issued. Rising edges while not in IDLE are ignored.

Capture path (1-cycle latency):
- When lval=1: pixel_data<=data; pixel_valid<=1; pixel_index = position in the current line, starting at 0.
- line_start=1 with index 0.
- When index would reach LINE_PIXELS: pixel_valid=0 for the rest of the line and overflow<=1 (sticky until reset).
- On lval falling: index clears, line_end pulses 1 cycle, line_count increments (wraps at 2^LINE_CNT_WIDTH).
- A lval=1 single-cycle line is valid: line_start with index 0, then line_end.
- Reset mid-line: the partial line is discarded; no line_end is produced.

Decomposition:
- Package linescanner_pkg:
  - exposure and load FSM state enums
  - default timings: T_CVC=48, T_CDS=7, T_SAMPLE=48, T_HOLD=6, LOAD_DELAY=3
- Sub-module linescanner_load_pulse_gen: the load FSM, parametrised by CNT_WIDTH. Instantiated once.

Test Plan:
- Defaults, single_shot=1, enable held high: rst_cvc low 113 cycles, rst_cds low 64 cycles starting 49 cycles after rst_cvc falls, sample high 49 cycles; exactly one sequence until enable is toggled.
- single_shot=0, t_*=0, enable high: period 5 cycles (4 phases + 1 IDLE); sample high 1 cycle per period; t_cvc changed mid-sequence only affects the next sequence.
- end_adc rising with load_delay=3: load_pulse high on the 5th cycle after the registered edge, for 1 cycle; end_adc held high 20 cycles gives no second pulse; end_adc low at delay cycle 2 still gives the pulse.
- lval high 10 cycles with data=0x10..0x19: pixel_valid 10 cycles one cycle later, indices 0..9, line_start with 0x10, line_end 1 cycle after the last valid pixel, line_count=1.
- LINE_PIXELS=8, lval high 12 cycles: 8 valid pixels, overflow=1 and stays 1 through the next normal line; line_count still increments.
- reset asserted mid-CDS phase and mid-line: next edge gives rst_cvc=1, rst_cds=1, sample=0, line_count=0, no line_end.

Source files
------------

// File: rtl/linescanner_pkg.sv
// Shared types and default timings for the line-scan capture sequencer.
//   exp_state_e  : exposure strobe sequencer states
//   load_state_e : end_adc-to-load_pulse generator states
//   T_*          : default phase lengths (minus 1) for the exposure sequence
package linescanner_pkg;

    typedef enum logic [2:0] {
        EXP_IDLE,
        EXP_CVC,
        EXP_CDS,
        EXP_SAMPLE,
        EXP_HOLD
    } exp_state_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_DELAY,
        LD_PULSE,
        LD_WAIT_LOW
    } load_state_e;

    localparam int unsigned T_CVC      = 48;
    localparam int unsigned T_CDS      = 7;
    localparam int unsigned T_SAMPLE   = 48;
    localparam int unsigned T_HOLD     = 6;
    localparam int unsigned LOAD_DELAY = 3;

endpackage

// File: rtl/linescanner_capture_sequencer_if.sv
// Pixel stream bundle between sensor pins and the downstream line buffer.
//   lval, data        : raw sensor line-valid and pixel data
//   pixel_*           : registered pixel, valid and index within the line
//   line_start/end    : line delimiters; line_count completed lines
//   overflow          : sticky flag, a line exceeded LINE_PIXELS
// slave is the capture block, master is the sensor/consumer side.
interface linescanner_capture_sequencer_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned LINE_PIXELS    = 2048,
    parameter int unsigned LINE_CNT_WIDTH = 16
);
    localparam int unsigned IDX_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

    logic                      lval;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH-1:0]     pixel_data;
    logic                      pixel_valid;
    logic [IDX_W-1:0]          pixel_index;
    logic                      line_start;
    logic                      line_end;
    logic [LINE_CNT_WIDTH-1:0] line_count;
    logic                      overflow;

    modport slave (
        input  lval, data,
        output pixel_data, pixel_valid, pixel_index, line_start, line_end,
               line_count, overflow
    );

    modport master (
        output lval, data,
        input  pixel_data, pixel_valid, pixel_index, line_start, line_end,
               line_count, overflow
    );

endinterface

// File: rtl/linescanner_load_pulse_gen.sv
// One-cycle load_pulse issued load_delay+1 cycles after a rising edge of end_adc.
//   pixel_clock, reset : clock, synchronous active-high reset
//   end_adc            : sensor ADC-done flag
//   load_delay         : delay minus 1, captured on the rising edge
//   load_pulse         : registered one-cycle strobe
module linescanner_load_pulse_gen
    import linescanner_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    input  logic                 end_adc,
    input  logic [CNT_WIDTH-1:0] load_delay,
    output logic                 load_pulse
);

    load_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] delay_q, delay_d;
    logic                 end_adc_q;
    logic                 load_pulse_q, load_pulse_d;

    // Next state; rising edges outside IDLE are ignored by construction.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        delay_d      = delay_q;
        load_pulse_d = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (end_adc && !end_adc_q) begin
                    state_d = LD_DELAY;
                    cnt_d   = '0;
                    delay_d = load_delay;
                end
            end
            LD_DELAY: begin
                if (cnt_q == delay_q) begin
                    state_d      = LD_PULSE;
                    load_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            LD_PULSE:    state_d = LD_WAIT_LOW;
            LD_WAIT_LOW: if (!end_adc) state_d = LD_IDLE;
            default:     state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q      <= LD_IDLE;
            cnt_q        <= '0;
            delay_q      <= '0;
            end_adc_q    <= 1'b0;
            load_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            delay_q      <= delay_d;
            end_adc_q    <= end_adc;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign load_pulse = load_pulse_q;

endmodule

// File: rtl/linescanner_capture_sequencer.sv
// Line-scan sensor front end: exposure strobes, ADC load pulse, pixel framing.
//   pixel_clock, reset        : clock, synchronous active-high reset
//   enable, single_shot       : arm the exposure sequence / free-run select
//   t_cvc..t_hold, load_delay : phase and delay lengths minus 1
//   end_adc                   : ADC-done flag feeding the load pulse generator
//   rst_cvc, rst_cds, sample  : exposure strobes; busy while sequencing
//   load_pulse                : one-cycle load strobe
//   cap                       : sensor pixel stream in, framed pixels out
module linescanner_capture_sequencer
    import linescanner_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned LINE_PIXELS    = 2048,
    parameter int unsigned LINE_CNT_WIDTH = 16
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 single_shot,
    input  logic [CNT_WIDTH-1:0] t_cvc,
    input  logic [CNT_WIDTH-1:0] t_cds,
    input  logic [CNT_WIDTH-1:0] t_sample,
    input  logic [CNT_WIDTH-1:0] t_hold,
    input  logic [CNT_WIDTH-1:0] load_delay,
    input  logic                 end_adc,
    output logic                 rst_cvc,
    output logic                 rst_cds,
    output logic                 sample,
    output logic                 load_pulse,
    output logic                 busy,
    linescanner_capture_sequencer_if.slave cap
);

    localparam int unsigned IDX_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int unsigned POS_W = IDX_W + 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(LINE_PIXELS);

    // ---------------- exposure sequencer ----------------
    exp_state_e           exp_state_q, exp_state_d;
    logic [CNT_WIDTH-1:0] exp_cnt_q, exp_cnt_d;
    logic [CNT_WIDTH-1:0] sh_cvc_q, sh_cvc_d, sh_cds_q, sh_cds_d;
    logic [CNT_WIDTH-1:0] sh_sample_q, sh_sample_d, sh_hold_q, sh_hold_d;
    logic [CNT_WIDTH-1:0] phase_lim;
    logic                 phase_done;
    logic                 armed_q, armed_d;
    logic                 rst_cvc_q, rst_cvc_d, rst_cds_q, rst_cds_d;
    logic                 sample_q, sample_d, busy_q, busy_d;

    // Strobes change on phase exits; timings are shadowed at sequence start.
    always_comb begin
        exp_state_d = exp_state_q;
        exp_cnt_d   = exp_cnt_q + CNT_WIDTH'(1);
        sh_cvc_d    = sh_cvc_q;
        sh_cds_d    = sh_cds_q;
        sh_sample_d = sh_sample_q;
        sh_hold_d   = sh_hold_q;
        armed_d     = armed_q;
        rst_cvc_d   = rst_cvc_q;
        rst_cds_d   = rst_cds_q;
        sample_d    = sample_q;
        phase_lim   = sh_cvc_q;
        case (exp_state_q)
            EXP_CDS:    phase_lim = sh_cds_q;
            EXP_SAMPLE: phase_lim = sh_sample_q;
            EXP_HOLD:   phase_lim = sh_hold_q;
            default:    phase_lim = sh_cvc_q;
        endcase
        phase_done = (exp_cnt_q == phase_lim);
        if (phase_done) exp_cnt_d = '0;
        case (exp_state_q)
            EXP_IDLE: begin
                exp_cnt_d = '0;
                if (enable && (armed_q || !single_shot)) begin
                    sh_cvc_d    = t_cvc;
                    sh_cds_d    = t_cds;
                    sh_sample_d = t_sample;
                    sh_hold_d   = t_hold;
                    rst_cvc_d   = 1'b0;
                    exp_state_d = EXP_CVC;
                    if (single_shot) armed_d = 1'b0;
                end else if (!enable) begin
                    armed_d = 1'b1;
                end
            end
            EXP_CVC: if (phase_done) begin
                exp_state_d = EXP_CDS;
                rst_cds_d   = 1'b0;
            end
            EXP_CDS: if (phase_done) begin
                exp_state_d = EXP_SAMPLE;
                sample_d    = 1'b1;
            end
            EXP_SAMPLE: if (phase_done) begin
                exp_state_d = EXP_HOLD;
                sample_d    = 1'b0;
            end
            EXP_HOLD: if (phase_done) begin
                exp_state_d = EXP_IDLE;
                rst_cvc_d   = 1'b1;
                rst_cds_d   = 1'b1;
            end
            default: exp_state_d = EXP_IDLE;
        endcase
        busy_d = (exp_state_d != EXP_IDLE);
    end

    // ---------------- pixel capture ----------------
    logic [POS_W-1:0]          pos_q, pos_d;
    logic                      lval_q;
    logic [DATA_WIDTH-1:0]     pixel_data_q, pixel_data_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0]          pixel_index_q, pixel_index_d;
    logic                      line_start_q, line_start_d;
    logic                      line_end_q, line_end_d;
    logic [LINE_CNT_WIDTH-1:0] line_count_q, line_count_d;
    logic                      overflow_q, overflow_d;

    // pos_q counts accepted pixels; it saturates at LINE_PIXELS on overflow.
    always_comb begin
        pos_d         = pos_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_index_d = pixel_index_q;
        line_start_d  = 1'b0;
        line_end_d    = 1'b0;
        line_count_d  = line_count_q;
        overflow_d    = overflow_q;
        if (cap.lval) begin
            if (pos_q < POS_MAX) begin
                pixel_data_d  = cap.data;
                pixel_valid_d = 1'b1;
                pixel_index_d = pos_q[IDX_W-1:0];
                line_start_d  = (pos_q == '0);
                pos_d         = pos_q + POS_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (lval_q) begin
            pos_d         = '0;
            pixel_index_d = '0;
            line_end_d    = 1'b1;
            line_count_d  = line_count_q + LINE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            exp_state_q   <= EXP_IDLE;
            exp_cnt_q     <= '0;
            sh_cvc_q      <= '0;
            sh_cds_q      <= '0;
            sh_sample_q   <= '0;
            sh_hold_q     <= '0;
            armed_q       <= 1'b0;
            rst_cvc_q     <= 1'b1;
            rst_cds_q     <= 1'b1;
            sample_q      <= 1'b0;
            busy_q        <= 1'b0;
            pos_q         <= '0;
            lval_q        <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            line_start_q  <= 1'b0;
            line_end_q    <= 1'b0;
            line_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            exp_state_q   <= exp_state_d;
            exp_cnt_q     <= exp_cnt_d;
            sh_cvc_q      <= sh_cvc_d;
            sh_cds_q      <= sh_cds_d;
            sh_sample_q   <= sh_sample_d;
            sh_hold_q     <= sh_hold_d;
            armed_q       <= armed_d;
            rst_cvc_q     <= rst_cvc_d;
            rst_cds_q     <= rst_cds_d;
            sample_q      <= sample_d;
            busy_q        <= busy_d;
            pos_q         <= pos_d;
            lval_q        <= cap.lval;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_index_q <= pixel_index_d;
            line_start_q  <= line_start_d;
            line_end_q    <= line_end_d;
            line_count_q  <= line_count_d;
            overflow_q    <= overflow_d;
        end
    end

    linescanner_load_pulse_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_load_pulse_gen (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .end_adc     (end_adc),
        .load_delay  (load_delay),
        .load_pulse  (load_pulse)
    );

    assign rst_cvc         = rst_cvc_q;
    assign rst_cds         = rst_cds_q;
    assign sample          = sample_q;
    assign busy            = busy_q;
    assign cap.pixel_data  = pixel_data_q;
    assign cap.pixel_valid = pixel_valid_q;
    assign cap.pixel_index = pixel_index_q;
    assign cap.line_start  = line_start_q;
    assign cap.line_end    = line_end_q;
    assign cap.line_count  = line_count_q;
    assign cap.overflow    = overflow_q;

endmodule

// File: tb/tb_linescanner_capture_sequencer.sv
// Bench for linescanner_capture_sequencer: directed scenarios plus random
// stimulus, every cycle compared against a timeline-based reference model.
module tb_linescanner_capture_sequencer;
    import linescanner_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 8;
    localparam int unsigned LP  = 16;
    localparam int unsigned LCW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, single_shot, end_adc;
    logic [CW-1:0] t_cvc, t_cds, t_sample, t_hold, load_delay;
    logic          rst_cvc, rst_cds, sample, load_pulse, busy;

    linescanner_capture_sequencer_if #(
        .DATA_WIDTH(DW), .LINE_PIXELS(LP), .LINE_CNT_WIDTH(LCW)
    ) cap_if ();

    linescanner_capture_sequencer #(
        .DATA_WIDTH(DW), .CNT_WIDTH(CW), .LINE_PIXELS(LP), .LINE_CNT_WIDTH(LCW)
    ) dut (
        .pixel_clock (clk),
        .reset       (reset),
        .enable      (enable),
        .single_shot (single_shot),
        .t_cvc       (t_cvc),
        .t_cds       (t_cds),
        .t_sample    (t_sample),
        .t_hold      (t_hold),
        .load_delay  (load_delay),
        .end_adc     (end_adc),
        .rst_cvc     (rst_cvc),
        .rst_cds     (rst_cds),
        .sample      (sample),
        .load_pulse  (load_pulse),
        .busy        (busy),
        .cap         (cap_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Exposure: a sequence is a time window [t0, t0+total); strobes follow from the offset.
    bit m_active, m_armed;
    int m_t0, m_l0, m_l1, m_l2, m_total;
    // Load: pulse lands at rise edge + delay + 1; release on first low end_adc after the pulse cycle.
    bit m_ld_active, m_end_prev;
    int m_ld_p;
    // Capture: the pixels accepted so far in the current line.
    logic [DW-1:0] m_line[$];
    bit m_lval_prev;
    int m_lines;

    bit e_rst_cvc, e_rst_cds, e_sample, e_busy, e_load;
    bit e_valid, e_start, e_end, e_ovf;
    logic [DW-1:0] e_data;
    int e_index;

    task automatic model_edge();
        if (reset) begin
            m_active = 0; m_armed = 0; m_ld_active = 0; m_end_prev = 0;
            m_line.delete(); m_lval_prev = 0; m_lines = 0;
            e_rst_cvc = 1; e_rst_cds = 1; e_sample = 0; e_busy = 0; e_load = 0;
            e_valid = 0; e_start = 0; e_end = 0; e_ovf = 0; e_data = '0; e_index = 0;
            return;
        end
        if (m_active && cyc == m_t0 + m_total) begin
            m_active = 0;
        end else if (!m_active) begin
            if (enable && (m_armed || !single_shot)) begin
                m_active = 1;
                m_t0 = cyc;
                m_l0 = int'(t_cvc) + 1;
                m_l1 = int'(t_cds) + 1;
                m_l2 = int'(t_sample) + 1;
                m_total = m_l0 + m_l1 + m_l2 + int'(t_hold) + 1;
                if (single_shot) m_armed = 0;
            end else if (!enable) begin
                m_armed = 1;
            end
        end
        if (m_active) begin
            int off;
            off = cyc - m_t0;
            e_rst_cvc = 0;
            e_rst_cds = (off < m_l0);
            e_sample  = (off >= m_l0 + m_l1) && (off < m_l0 + m_l1 + m_l2);
            e_busy    = 1;
        end else begin
            e_rst_cvc = 1; e_rst_cds = 1; e_sample = 0; e_busy = 0;
        end

        if (m_ld_active && cyc >= m_ld_p + 2 && !end_adc)
            m_ld_active = 0;
        else if (!m_ld_active && end_adc && !m_end_prev) begin
            m_ld_active = 1;
            m_ld_p = cyc + int'(load_delay) + 1;
        end
        e_load = m_ld_active && (cyc == m_ld_p);
        m_end_prev = end_adc;

        e_valid = 0; e_start = 0; e_end = 0;
        if (cap_if.lval) begin
            if (m_line.size() < int'(LP)) begin
                m_line.push_back(cap_if.data);
                e_valid = 1;
                e_data  = cap_if.data;
                e_index = m_line.size() - 1;
                e_start = (m_line.size() == 1);
            end else begin
                e_ovf = 1;
            end
        end else if (m_lval_prev) begin
            m_line.delete();
            e_index = 0;
            e_end = 1;
            m_lines++;
        end
        m_lval_prev = cap_if.lval;
    endtask

    task automatic compare_all();
        check("rst_cvc",     32'(rst_cvc),             32'(e_rst_cvc));
        check("rst_cds",     32'(rst_cds),             32'(e_rst_cds));
        check("sample",      32'(sample),              32'(e_sample));
        check("busy",        32'(busy),                32'(e_busy));
        check("load_pulse",  32'(load_pulse),          32'(e_load));
        check("pixel_valid", 32'(cap_if.pixel_valid),  32'(e_valid));
        check("pixel_data",  32'(cap_if.pixel_data),   32'(e_data));
        check("pixel_index", 32'(cap_if.pixel_index),  32'(e_index));
        check("line_start",  32'(cap_if.line_start),   32'(e_start));
        check("line_end",    32'(cap_if.line_end),     32'(e_end));
        check("line_count",  32'(cap_if.line_count),   32'(m_lines % 65536));
        check("overflow",    32'(cap_if.overflow),     32'(e_ovf));
    endtask

    // ---------------- output monitor for directed measurements ----------------
    int mon_cvc_low, mon_cds_low, mon_smp_hi, mon_cvc_falls, mon_period;
    int mon_cvc_fall_t, mon_cds_fall_t, mon_ld_pulses, mon_ld_t;
    int mon_valid, mon_line_ends;
    logic [DW-1:0] mon_start_data;
    bit mon_prev_cvc = 1, mon_prev_cds = 1;

    task automatic mon_clear();
        mon_cvc_low = 0; mon_cds_low = 0; mon_smp_hi = 0; mon_cvc_falls = 0;
        mon_ld_pulses = 0; mon_valid = 0; mon_line_ends = 0;
    endtask

    task automatic monitor();
        if (!rst_cvc) mon_cvc_low++;
        if (!rst_cds) mon_cds_low++;
        if (sample)   mon_smp_hi++;
        if (!rst_cvc && mon_prev_cvc) begin
            mon_cvc_falls++;
            mon_period = cyc - mon_cvc_fall_t;
            mon_cvc_fall_t = cyc;
        end
        if (!rst_cds && mon_prev_cds) mon_cds_fall_t = cyc;
        if (load_pulse) begin mon_ld_pulses++; mon_ld_t = cyc; end
        if (cap_if.pixel_valid) mon_valid++;
        if (cap_if.line_end) mon_line_ends++;
        if (cap_if.line_start) mon_start_data = cap_if.pixel_data;
        mon_prev_cvc = rst_cvc;
        mon_prev_cds = rst_cds;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
        monitor();
    endtask

    task automatic default_timings();
        t_cvc = CW'(T_CVC); t_cds = CW'(T_CDS); t_sample = CW'(T_SAMPLE);
        t_hold = CW'(T_HOLD); load_delay = CW'(LOAD_DELAY);
    endtask

    int rise_t;

    initial begin
        reset = 1; enable = 0; single_shot = 1; end_adc = 0;
        default_timings();
        cap_if.lval = 0; cap_if.data = '0;
        mon_clear();
        repeat (3) step();
        reset = 0;
        repeat (3) step();

        // single shot with default timings, enable held high
        mon_clear();
        enable = 1;
        repeat (300) step();
        check("ss_cvc_low_width",  32'(mon_cvc_low),   113);
        check("ss_cds_low_width",  32'(mon_cds_low),   64);
        check("ss_sample_width",   32'(mon_smp_hi),    49);
        check("ss_sequence_count", 32'(mon_cvc_falls), 1);
        check("ss_cds_offset",     32'(mon_cds_fall_t - mon_cvc_fall_t), 49);
        enable = 0;
        repeat (2) step();
        mon_clear();
        enable = 1;
        repeat (150) step();
        check("ss_retrigger_count", 32'(mon_cvc_falls), 1);

        // free-running with minimum phase lengths
        enable = 0; single_shot = 0;
        t_cvc = '0; t_cds = '0; t_sample = '0; t_hold = '0;
        repeat (2) step();
        mon_clear();
        enable = 1;
        repeat (20) step();
        check("fr_period",      32'(mon_period), 5);
        check("fr_sample_hits", 32'(mon_smp_hi), 4);
        repeat (2) step();
        t_cvc = CW'(3);
        repeat (4) step();
        check("fr_current_seq_unchanged", 32'(mon_period), 5);
        repeat (20) step();
        check("fr_next_seq_period", 32'(mon_period), 8);
        enable = 0; single_shot = 1;
        default_timings();
        repeat (10) step();

        // load pulse: long end_adc high, then early fall during the delay
        mon_clear();
        end_adc = 1;
        step();
        rise_t = cyc;
        repeat (19) step();
        end_adc = 0;
        repeat (3) step();
        check("ld_pulse_count",   32'(mon_ld_pulses), 1);
        check("ld_pulse_latency", 32'(mon_ld_t - rise_t), 4);
        mon_clear();
        end_adc = 1;
        step();
        step();
        end_adc = 0;
        repeat (8) step();
        check("ld_early_fall_pulse", 32'(mon_ld_pulses), 1);

        // capture: normal 10-pixel line
        mon_clear();
        for (int i = 0; i < 10; i++) begin
            cap_if.lval = 1;
            cap_if.data = DW'(16 + i);
            step();
        end
        cap_if.lval = 0; cap_if.data = '0;
        repeat (3) step();
        check("cap_valid_count", 32'(mon_valid), 10);
        check("cap_line_ends",   32'(mon_line_ends), 1);
        check("cap_first_pixel", 32'(mon_start_data), 32'h10);
        check("cap_line_count",  32'(cap_if.line_count), 1);

        // capture: overlong line then a normal one
        mon_clear();
        for (int i = 0; i < 20; i++) begin
            cap_if.lval = 1;
            cap_if.data = DW'($urandom);
            step();
        end
        cap_if.lval = 0;
        repeat (3) step();
        check("ovf_valid_count", 32'(mon_valid), 16);
        check("ovf_flag",        32'(cap_if.overflow), 1);
        check("ovf_line_count",  32'(cap_if.line_count), 2);
        mon_clear();
        for (int i = 0; i < 5; i++) begin
            cap_if.lval = 1;
            cap_if.data = DW'($urandom);
            step();
        end
        cap_if.lval = 0;
        repeat (3) step();
        check("ovf_next_valid",  32'(mon_valid), 5);
        check("ovf_sticky",      32'(cap_if.overflow), 1);
        check("ovf_next_count",  32'(cap_if.line_count), 3);

        // reset in the middle of the CDS phase and of a line
        enable = 0;
        repeat (3) step();
        enable = 1;
        step();
        repeat (48) step();
        cap_if.lval = 1;
        repeat (4) step();
        check("rc_in_cds", 32'(rst_cds), 0);
        reset = 1;
        step();
        check("rc_rst_cvc",    32'(rst_cvc), 1);
        check("rc_rst_cds",    32'(rst_cds), 1);
        check("rc_sample",     32'(sample), 0);
        check("rc_line_count", 32'(cap_if.line_count), 0);
        reset = 0; cap_if.lval = 0;
        mon_clear();
        repeat (3) step();
        check("rc_no_line_end", 32'(mon_line_ends), 0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 63) == 0) single_shot = ~single_shot;
            if ($urandom_range(0, 7) == 0) begin
                t_cvc    = CW'($urandom_range(0, 4));
                t_cds    = CW'($urandom_range(0, 4));
                t_sample = CW'($urandom_range(0, 4));
                t_hold   = CW'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 7) == 0)  end_adc = ~end_adc;
            if ($urandom_range(0, 15) == 0) load_delay = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0)  cap_if.lval = ~cap_if.lval;
            cap_if.data = DW'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
